// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, IF/ID register plus 1-entry skid buffer, redirect flush.
// Latency: request accept -> id_valid = response latency + 1; requests stall when both slots are full.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] instr_reg,
    output logic [31:0] prev_pc
);

    logic [31:0] pc;
    logic        outstanding;
    logic [31:0] out_addr;
    logic        drop;
    logic        skid_valid;
    logic [31:0] skid_data;
    logic [31:0] skid_addr;

    logic [1:0]  used_slots;
    logic        req_fire;
    logic        rsp_take;
    logic        id_fire;
    logic        if_id_free;

    // A request is only launched when its response is guaranteed a slot to land in.
    assign used_slots     = {1'b0, id_valid} + {1'b0, skid_valid};
    assign imem_req_valid = rst_n & ~outstanding & ~redirect_valid & (used_slots != 2'd2);
    assign imem_req_addr  = {pc[31:2], 2'b00};

    assign req_fire   = imem_req_valid & imem_req_ready;
    assign rsp_take   = imem_rsp_valid & outstanding & ~drop;
    assign id_fire    = id_valid & id_ready;
    assign if_id_free = ~id_valid | id_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            out_addr    <= 32'h0;
            drop        <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                pc <= pc + 32'd4;
            end

            // A response in the redirect cycle retires the request itself, so no drop is armed.
            if (req_fire) begin
                outstanding <= 1'b1;
                out_addr    <= imem_req_addr;
            end else if (imem_rsp_valid && outstanding) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end else if (redirect_valid && outstanding) begin
                drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            instr_reg  <= NOP_INSTR;
            prev_pc    <= 32'h0;
            skid_valid <= 1'b0;
            skid_data  <= 32'h0;
            skid_addr  <= 32'h0;
        end else if (redirect_valid) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
            instr_reg  <= NOP_INSTR;
        end else if (if_id_free) begin
            // The skid entry is always older than an arriving response, so it moves first.
            if (skid_valid) begin
                id_valid   <= 1'b1;
                instr_reg  <= skid_data;
                prev_pc    <= skid_addr;
                skid_valid <= rsp_take;
                if (rsp_take) begin
                    skid_data <= imem_rsp_data;
                    skid_addr <= out_addr;
                end
            end else if (rsp_take) begin
                id_valid  <= 1'b1;
                instr_reg <= imem_rsp_data;
                prev_pc   <= out_addr;
            end else begin
                id_valid  <= 1'b0;
                instr_reg <= NOP_INSTR;
            end
        end else if (rsp_take) begin
            skid_valid <= 1'b1;
            skid_data  <= imem_rsp_data;
            skid_addr  <= out_addr;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder + address/stream model feeding a scoreboard checked by a decode-side monitor.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] instr_reg;
    logic [31:0] prev_pc;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .instr_reg      (instr_reg),
        .prev_pc        (prev_pc)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    int          tests = 0;
    int          fails = 0;
    int          transfers = 0;
    item_t       exp_q[$];

    int unsigned ready_pct = 100;
    int unsigned lat_min   = 1;
    int unsigned lat_max   = 1;
    int unsigned stale_pct = 0;
    bit          stale_now = 0;

    bit          m_pending;
    bit          m_killed;
    logic [31:0] m_paddr;
    logic [31:0] m_exp_pc;
    int unsigned m_cnt;

    bit          held;
    logic [31:0] h_instr;
    logic [31:0] h_pc;
    item_t       item;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic set_mem(input int unsigned rp, input int unsigned lmin, input int unsigned lmax,
                           input int unsigned sp);
        ready_pct = rp;
        lat_min   = lmin;
        lat_max   = lmax;
        stale_pct = sp;
    endtask

    // Memory responder and request-address model: addresses run sequentially from reset/redirect
    // targets; a response becomes an expected instruction unless a redirect hit while it was in flight.
    initial begin : mem_proc
        m_pending = 0; m_killed = 0; m_paddr = 0; m_exp_pc = RESET_PC; m_cnt = 0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pending = 0;
                m_killed  = 0;
                m_exp_pc  = RESET_PC;
            end else begin
                if (redirect_valid) begin
                    m_exp_pc = {redirect_pc[31:2], 2'b00};
                    if (m_pending) m_killed = 1;
                end
                if (imem_req_valid) begin
                    chk1("one_outstanding", m_pending, 1'b0);
                    chk1("no_req_in_redirect", redirect_valid, 1'b0);
                end
                if (imem_rsp_valid && m_pending) begin
                    if (!m_killed) exp_q.push_back({m_paddr, word_of(m_paddr)});
                    m_pending = 0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, m_exp_pc);
                    m_paddr   = imem_req_addr;
                    m_exp_pc  = m_exp_pc + 32'd4;
                    m_pending = 1;
                    m_killed  = 0;
                    m_cnt     = $urandom_range(lat_max, lat_min);
                end
            end
            @(posedge clk);
            #1;
            imem_req_ready = ($urandom_range(99, 0) < ready_pct);
            if (m_pending && m_cnt > 0) m_cnt--;
            if (m_pending && m_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_of(m_paddr);
            end else if (!m_pending && (stale_now || $urandom_range(99, 0) < stale_pct)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = $urandom;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    // Decode-side monitor: pops the scoreboard on every transfer.
    initial begin : monitor
        held = 0; h_instr = 0; h_pc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                held = 0;
            end else begin
                if (held) begin
                    chk1("stall_hold_valid", id_valid, 1'b1);
                    check("stall_hold_instr", instr_reg, h_instr);
                    check("stall_hold_pc", prev_pc, h_pc);
                end
                held = 0;
                if (!id_valid) check("idle_nop", instr_reg, NOP);
                if (redirect_valid) begin
                    exp_q.delete();
                end else if (id_valid && id_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_instr: got pc %h instr %h, required no instruction", prev_pc, instr_reg);
                    end else begin
                        item = exp_q.pop_front();
                        check("id_pc", prev_pc, item.addr);
                        check("id_instr", instr_reg, item.data);
                        transfers++;
                    end
                end else if (id_valid) begin
                    held    = 1;
                    h_instr = instr_reg;
                    h_pc    = prev_pc;
                end
            end
        end
    end

    initial begin : driver
        logic ok;
        rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        repeat (2) @(negedge clk);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_id_valid", id_valid, 1'b0);
        check("rst_instr", instr_reg, NOP);
        check("rst_prev_pc", prev_pc, 32'h0);

        // First fetch out of reset with a 1-cycle memory
        id_ready = 1'b1;
        set_mem(100, 1, 1, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        chk1("first_not_yet_valid", id_valid, 1'b0);
        @(negedge clk);
        chk1("first_id_valid", id_valid, 1'b1);
        check("first_instr", instr_reg, 32'h00A0_0093);
        check("first_prev_pc", prev_pc, 32'h0);
        check("second_req_addr", imem_req_addr, 32'h4);

        // Decode stalled: second word parks in the skid buffer
        @(posedge clk); #1 rst_n = 1'b0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk1("skid_no_third_req", imem_req_valid, 1'b0);
        check("skid_instr_stable", instr_reg, word_of(32'h0));
        check("skid_prev_pc", prev_pc, 32'h0);
        @(posedge clk); #1 id_ready = 1'b1; set_mem(100, 3, 3, 0);
        @(negedge clk);
        check("order_first_pc", prev_pc, 32'h0);
        check("order_first_instr", instr_reg, word_of(32'h0));
        @(posedge clk); #1 id_ready = 1'b0;
        @(negedge clk);
        check("order_second_pc", prev_pc, 32'h4);
        check("order_second_instr", instr_reg, word_of(32'h4));
        chk1("req8_valid", imem_req_valid, 1'b1);
        check("req8_addr", imem_req_addr, 32'h8);

        // Redirect while the request to 8 is in flight
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        @(posedge clk); #1 redirect_valid = 1'b0; id_ready = 1'b1; set_mem(100, 1, 1, 0);
        @(negedge clk);
        chk1("redir_id_valid", id_valid, 1'b0);
        check("redir_instr_nop", instr_reg, NOP);
        chk1("redir_wait_drop", imem_req_valid, 1'b0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = imem_req_valid; end
        chk1("redir_req_seen", ok, 1'b1);
        check("redir_req_addr", imem_req_addr, 32'h100);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = id_valid; end
        chk1("redir_id_seen", ok, 1'b1);
        check("redir_first_pc", prev_pc, 32'h100);

        // Redirect in the same cycle as a response, unaligned target
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = imem_req_valid & imem_req_ready; end
        chk1("same_cycle_hs_seen", ok, 1'b1);
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk1("same_cycle_req_valid", imem_req_valid, 1'b1);
        check("same_cycle_req_addr", imem_req_addr, 32'h100);
        chk1("same_cycle_id_valid", id_valid, 1'b0);

        // PC wrap at the top of the address space
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1 redirect_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = imem_req_valid & imem_req_ready; end
        chk1("wrap_hs_seen", ok, 1'b1);
        check("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = imem_req_valid; end
        chk1("wrap_next_seen", ok, 1'b1);
        check("wrap_next_addr", imem_req_addr, 32'h0);

        // Reset mid-operation with an instruction held and a request outstanding
        @(posedge clk); #1 id_ready = 1'b0; set_mem(100, 4, 4, 0);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = id_valid & imem_req_valid & imem_req_ready;
        end
        chk1("midrst_setup_seen", ok, 1'b1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk1("midrst_req_valid", imem_req_valid, 1'b0);
        chk1("midrst_id_valid", id_valid, 1'b0);
        check("midrst_instr", instr_reg, NOP);
        check("midrst_prev_pc", prev_pc, 32'h0);
        stale_now = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        stale_now = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = id_valid; end
        chk1("midrst_id_seen", ok, 1'b1);
        check("midrst_first_pc", prev_pc, RESET_PC);
        check("midrst_first_instr", instr_reg, word_of(RESET_PC));

        // Randomized traffic against the model
        set_mem(70, 1, 3, 10);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            id_ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(99, 0) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk1("random_progress", transfers > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
